// File: rtl/rr_grant_fsm_pkg.sv
// Shared types and helpers for the round-robin grant FSM.
package rr_arb_pkg;

  // Arbiter phases; 2'b11 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Upper bound on requester count supported by onehot().
  localparam int MAX_N = 64;

  // One-hot mask with bit idx set; empty when idx is out of range for n requesters.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_N) v[idx[5:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_grant_fsm_if.sv
// Requester-side bundle of the round-robin arbiter.
interface rr_grant_fsm_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           grant_pulse;
  logic           timeout;

  // Requesters drive req/done and observe the grant.
  modport master (
    output req, done,
    input  gnt, gnt_id, busy, grant_pulse, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, grant_pulse, timeout
  );
endinterface

// File: rtl/rr_grant_fsm_pick.sv
// Round-robin winner selection: rotate req so ptr sits at bit 0, take the
// lowest set bit, then rotate the index back (explicit wrap, no modulo).
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   pos;
  logic [IDW:0]   sum;

  // Rotate, priority-encode from the lowest bit, un-rotate with a single wrap.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    pos = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) pos = (IDW+1)'(i);
    sum    = pos + {1'b0, ptr};
    winner = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
    any    = |req;
  end

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter FSM: one owner at a time, grant held until done,
// request drop or MAX_HOLD cycles, followed by one dead GAP cycle.
module rr_grant_fsm
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  rr_grant_fsm_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(MAX_HOLD + 1);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  hold_cnt;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic           busy_q;

  logic [IDW-1:0] winner;
  logic           any;
  logic           own_req;
  logic           own_done;
  logic           at_limit;
  logic           grant_exit;
  logic [IDW-1:0] next_ptr;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  // Only the owner's req/done matter; everything else is ignored in GRANT.
  assign own_req    = bus.req[owner];
  assign own_done   = bus.done[owner];
  assign at_limit   = (hold_cnt == CW'(MAX_HOLD - 1));
  assign grant_exit = own_done | ~own_req | at_limit;
  assign next_ptr   = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;

  // State, pointer, owner, hold counter and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner    <= winner;
            gnt_id_q <= winner;
            hold_cnt <= '0;
            gnt_q    <= N'(onehot(32'(winner), N));
            busy_q   <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (grant_exit) begin
            ptr   <= next_ptr;
            gnt_q <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  // Arbitration cycle marker; held low while reset is asserted.
  assign bus.grant_pulse = ~reset & (state == IDLE) & any;
  // Timeout only when the limit alone ends the grant (done takes precedence).
  assign bus.timeout = (state == GRANT) & at_limit & ~own_done & own_req;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Scoreboard bench for rr_grant_fsm: a driver issues req/done each cycle and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_rr_grant_fsm;
  localparam int N   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;

  typedef struct {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           pulse;
    logic           tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rr_grant_fsm_if #(.N(N)) bus();

  rr_grant_fsm #(.N(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, for how many cycles so far,
  // where the search starts next, and whether a handover gap is pending.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_gap   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_gap = 0;
  endtask

  // Entered at a falling edge: drive, predict this cycle, advance model, wait.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d);
    exp_t e;
    int w;
    bus.req = r; bus.done = d;
    #1;
    e.gnt = '0; e.busy = 1'b0; e.pulse = 1'b0; e.tmo = 1'b0;
    e.gnt_id = IDW'(m_last);
    if (m_gap) begin
      e.busy = 1'b1;
      m_gap = 0;
    end else if (m_owner < 0) begin
      e.pulse = (r != '0);
      w = pick(r);
      if (w >= 0) begin m_owner = w; m_held = 1; m_last = w; end
    end else begin
      e.gnt[m_owner] = 1'b1;
      e.busy = 1'b1;
      e.tmo = (m_held == MH) && !d[m_owner] && r[m_owner];
      if (d[m_owner] || !r[m_owner] || m_held == MH) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_gap = 1;
      end else begin
        m_held++;
      end
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  // Entered at a falling edge: assert reset mid-cycle, check the asynchronous
  // clear, release at the next falling edge.
  task automatic pulse_reset(input logic [N-1:0] r);
    bus.req = r; bus.done = '0;
    #3 reset = 1'b1;
    #1;
    chk("rst_gnt",    32'(bus.gnt), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 0);
    chk("rst_pulse",  32'(bus.grant_pulse), 0);
    chk("rst_tmo",    32'(bus.timeout), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("gnt",         32'(bus.gnt), 32'(e.gnt));
        chk("gnt_id",      32'(bus.gnt_id), 32'(e.gnt_id));
        chk("busy",        32'(bus.busy), 32'(e.busy));
        chk("grant_pulse", 32'(bus.grant_pulse), 32'(e.pulse));
        chk("timeout",     32'(bus.timeout), 32'(e.tmo));
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    bus.req = '0; bus.done = '0;
    @(negedge clk);

    // Reset with all requesting, then arbitration on release.
    pulse_reset(4'b1111);
    cycle(4'b1111, '0);

    // Round-robin: each owner signals done in its second grant cycle.
    for (int i = 0; i < 20; i++) begin
      d = '0;
      if (m_owner >= 0 && m_held == 2) d[m_owner] = 1'b1;
      cycle(4'b1111, d);
    end

    // Timeout on a lone requester, then re-grant.
    pulse_reset(4'b0100);
    for (int i = 0; i < 12; i++) cycle(4'b0100, '0);

    // Foreign done ignored; owner dropping req ends the grant, ptr moves on.
    pulse_reset(4'b0010);
    cycle(4'b0010, '0);
    cycle(4'b0010, '0);
    cycle(4'b0010, 4'b1000);
    cycle(4'b0000, '0);
    cycle(4'b0000, '0);
    cycle(4'b1111, '0);
    cycle(4'b1111, '0);

    // Owner 3 exits with done on the limit cycle; pointer wraps to 0.
    pulse_reset(4'b1000);
    cycle(4'b1000, '0);
    for (int i = 0; i < 3; i++) cycle(4'b1000, '0);
    cycle(4'b1000, 4'b1000);
    cycle(4'b1001, '0);
    cycle(4'b1001, '0);
    cycle(4'b1001, '0);

    // Reset in the middle of a grant to requester 1.
    pulse_reset(4'b0000);
    cycle(4'b0010, '0);
    cycle(4'b0010, '0);
    pulse_reset(4'b0110);
    cycle(4'b0110, '0);
    cycle(4'b0110, '0);

    // Randomized traffic with sticky requests and sparse done/reset.
    r = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      d = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 4) == 0) d[b] = 1'b1;
      if ($urandom_range(0, 199) == 0) pulse_reset(r);
      else cycle(r, d);
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
